// File: rtl/neuron_pkg.sv
// Shared constants and FSM state type for the neuron output stage.
package neuron_pkg;

  localparam int ACC_W = 22;
  localparam int OUT_W = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } argmax_state_t;

endpackage

// File: rtl/neuron_argmax_relu_sat.sv
// Combinational arithmetic shift, ReLU and unsigned saturation of one accumulator value.
module relu_sat #(
  parameter int ACC_W = 22,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] act_o
);

  logic signed [ACC_W-1:0]       shifted;
  logic        [ACC_W-OUT_W-1:0] upper;

  always_comb begin
    shifted = $signed(acc_i) >>> SHIFT;
    upper   = shifted[ACC_W-1:OUT_W];
    // A non-negative value with any bit above OUT_W set exceeds the output range.
    if (shifted[ACC_W-1]) begin
      act_o = '0;
    end else if (|upper) begin
      act_o = '1;
    end else begin
      act_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_argmax.sv
// Neuron output stage: per-sample activation stream plus per-frame argmax result
// offered through a valid/ready handshake.
module neuron_argmax #(
  parameter int ACC_W       = neuron_pkg::ACC_W,
  parameter int NUM_CLASSES = 10,
  parameter int SHIFT       = 6,
  parameter int OUT_W       = neuron_pkg::OUT_W,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_valid,
  output logic             acc_ready,
  output logic [OUT_W-1:0] act_out,
  output logic             act_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [OUT_W-1:0] class_score,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             dbg_state
);

  import neuron_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready depends only on registered state and valid is never withdrawn by us.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t    state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [OUT_W-1:0] best_score_q, best_score_d;
  logic [OUT_W-1:0] act_q, act_d;
  logic             act_valid_q, act_valid_d;
  logic [OUT_W-1:0] act_comb;

  relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_relu_sat (
    .acc_i (acc_in),
    .act_o (act_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      act_q        <= '0;
      act_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      act_q        <= act_d;
      act_valid_q  <= act_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    act_d        = act_q;
    act_valid_d  = 1'b0;
    case (state_q)
      ACC: begin
        if (acc_valid) begin
          act_d       = act_comb;
          act_valid_d = 1'b1;
          // Strict compare keeps the earliest index on ties; slot 0 seeds the frame.
          if ((cnt_q == '0) || (act_comb > best_score_q)) begin
            best_score_d = act_comb;
            best_idx_d   = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  assign acc_ready    = (state_q == ACC);
  assign result_valid = (state_q == HOLD);
  assign act_out      = act_q;
  assign act_valid    = act_valid_q;
  assign class_idx    = best_idx_q;
  assign class_score  = best_score_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench for neuron_argmax: a 10-class instance and a 2-class instance.
module tb_neuron_argmax;

  logic clk;

  // 10-class instance
  logic        rst_n;
  logic [21:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic [7:0]  act_out;
  logic        act_valid;
  logic [3:0]  class_idx;
  logic [7:0]  class_score;
  logic        result_valid;
  logic        result_ready;
  logic        dbg_state;

  // 2-class instance
  logic        rst2_n;
  logic [21:0] acc2_in;
  logic        acc2_valid;
  logic        acc2_ready;
  logic [7:0]  act2_out;
  logic        act2_valid;
  logic [0:0]  class2_idx;
  logic [7:0]  class2_score;
  logic        result2_valid;
  logic        result2_ready;
  logic        dbg2_state;

  int total;
  int bad;

  logic [21:0] frame_v[10];
  logic [7:0]  frame_a[10];

  neuron_argmax #(
    .ACC_W(22), .NUM_CLASSES(10), .SHIFT(6), .OUT_W(8), .IDX_W(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_in       (acc_in),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .act_out      (act_out),
    .act_valid    (act_valid),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .dbg_state    (dbg_state)
  );

  neuron_argmax #(
    .ACC_W(22), .NUM_CLASSES(2), .SHIFT(6), .OUT_W(8), .IDX_W(1)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst2_n),
    .acc_in       (acc2_in),
    .acc_valid    (acc2_valid),
    .acc_ready    (acc2_ready),
    .act_out      (act2_out),
    .act_valid    (act2_valid),
    .class_idx    (class2_idx),
    .class_score  (class2_score),
    .result_valid (result2_valid),
    .result_ready (result2_ready),
    .dbg_state    (dbg2_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [21:0] v);
    acc_in    = v;
    acc_valid = 1'b1;
    cyc();
  endtask

  task automatic send2(input logic [21:0] v);
    acc2_in    = v;
    acc2_valid = 1'b1;
    cyc();
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 10; i++) begin
      send(frame_v[i]);
      check({tag, "_act"}, 32'(act_out), 32'(frame_a[i]));
      check({tag, "_actv"}, 32'(act_valid), 32'd1);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    rst2_n        = 1'b0;
    acc_in        = '0;
    acc_valid     = 1'b0;
    result_ready  = 1'b0;
    acc2_in       = '0;
    acc2_valid    = 1'b0;
    result2_ready = 1'b0;

    // reset state
    repeat (2) cyc();
    check("rst_ready",  32'(acc_ready),    32'd1);
    check("rst_actv",   32'(act_valid),    32'd0);
    check("rst_act",    32'(act_out),      32'd0);
    check("rst_idx",    32'(class_idx),    32'd0);
    check("rst_score",  32'(class_score),  32'd0);
    check("rst_resv",   32'(result_valid), 32'd0);
    check("rst2_ready", 32'(acc2_ready),   32'd1);
    check("rst2_resv",  32'(result2_valid), 32'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    cyc();

    // scaling / clamp, each followed by a gap to see the pulse end
    send(22'h00003F);
    check("sc_3f_act", 32'(act_out), 32'd0);
    check("sc_3f_v",   32'(act_valid), 32'd1);
    acc_valid = 1'b0;
    cyc();
    check("sc_3f_pulse", 32'(act_valid), 32'd0);

    send(22'h3FFFC0);
    check("sc_neg_act", 32'(act_out), 32'd0);
    check("sc_neg_v",   32'(act_valid), 32'd1);
    acc_valid = 1'b0;
    cyc();
    check("sc_neg_pulse", 32'(act_valid), 32'd0);

    send(22'h1FFFFF);
    check("sc_sat_act", 32'(act_out), 32'd255);
    check("sc_sat_v",   32'(act_valid), 32'd1);
    acc_valid = 1'b0;
    cyc();
    check("sc_sat_pulse", 32'(act_valid), 32'd0);

    send(22'h000640);
    check("sc_25_act", 32'(act_out), 32'd25);
    check("sc_25_v",   32'(act_valid), 32'd1);
    check("mid_idx",   32'(class_idx), 32'd2);
    check("mid_score", 32'(class_score), 32'd255);
    acc_valid = 1'b0;

    // asynchronous reset between edges after 4 samples
    #3 rst_n = 1'b0;
    #1;
    check("arst_act",   32'(act_out),      32'd0);
    check("arst_actv",  32'(act_valid),    32'd0);
    check("arst_idx",   32'(class_idx),    32'd0);
    check("arst_score", 32'(class_score),  32'd0);
    check("arst_ready", 32'(acc_ready),    32'd1);
    check("arst_resv",  32'(result_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // full frame after reset, max 200 at index 7
    frame_a = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd200, 8'd199, 8'd5};
    for (int i = 0; i < 10; i++) frame_v[i] = {8'd0, frame_a[i], 6'd0};
    run_frame("f200");
    check("f200_resv",  32'(result_valid), 32'd1);
    check("f200_ready", 32'(acc_ready),    32'd0);
    check("f200_idx",   32'(class_idx),    32'd7);
    check("f200_score", 32'(class_score),  32'd200);
    acc_valid    = 1'b0;
    result_ready = 1'b1;
    cyc();
    check("f200_hs_resv",  32'(result_valid), 32'd0);
    check("f200_hs_ready", 32'(acc_ready),    32'd1);
    result_ready = 1'b0;

    // tie frame: 40 at indices 2 and 4
    frame_a = '{8'd3, 8'd9, 8'd40, 8'd7, 8'd40, 8'd1, 8'd0, 8'd12, 8'd39, 8'd2};
    for (int i = 0; i < 10; i++) frame_v[i] = {8'd0, frame_a[i], 6'd0};
    run_frame("tie");
    check("tie_resv",  32'(result_valid), 32'd1);
    check("tie_ready", 32'(acc_ready),    32'd0);
    check("tie_idx",   32'(class_idx),    32'd2);
    check("tie_score", 32'(class_score),  32'd40);

    // backpressure: upstream keeps offering a large sample, nothing is taken
    acc_in    = 22'h003FC0;
    acc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_resv",  32'(result_valid), 32'd1);
      check("bp_ready", 32'(acc_ready),    32'd0);
      check("bp_actv",  32'(act_valid),    32'd0);
      check("bp_idx",   32'(class_idx),    32'd2);
      check("bp_score", 32'(class_score),  32'd40);
    end
    acc_valid    = 1'b0;
    result_ready = 1'b1;
    cyc();
    check("bp_hs_ready", 32'(acc_ready),    32'd1);
    check("bp_hs_resv",  32'(result_valid), 32'd0);
    result_ready = 1'b0;

    // all non-positive frame, must start fresh at index 0
    frame_v = '{22'h3FFFFF, 22'h200000, 22'h3FFFC0, 22'h000000, 22'h3F0000,
                22'h3FFF00, 22'h2ABCDE, 22'h3FFFFE, 22'h300000, 22'h3FFFC1};
    for (int i = 0; i < 10; i++) frame_a[i] = 8'd0;
    run_frame("neg");
    check("neg_resv",  32'(result_valid), 32'd1);
    check("neg_idx",   32'(class_idx),    32'd0);
    check("neg_score", 32'(class_score),  32'd0);
    acc_valid    = 1'b0;
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;

    // two-class instance: 5,6 then immediately 6,5
    send2({8'd0, 8'd5, 6'd0});
    check("n2_a_act", 32'(act2_out), 32'd5);
    check("n2_a_resv", 32'(result2_valid), 32'd0);
    send2({8'd0, 8'd6, 6'd0});
    check("n2_a_act2",  32'(act2_out),      32'd6);
    check("n2_a_resv2", 32'(result2_valid), 32'd1);
    check("n2_a_ready", 32'(acc2_ready),    32'd0);
    check("n2_a_idx",   32'(class2_idx),    32'd1);
    check("n2_a_score", 32'(class2_score),  32'd6);
    result2_ready = 1'b1;
    send2({8'd0, 8'd6, 6'd0});
    check("n2_hs_ready", 32'(acc2_ready),    32'd1);
    check("n2_hs_resv",  32'(result2_valid), 32'd0);
    check("n2_hs_actv",  32'(act2_valid),    32'd0);
    result2_ready = 1'b0;
    cyc();
    check("n2_b_act", 32'(act2_out), 32'd6);
    send2({8'd0, 8'd5, 6'd0});
    acc2_valid = 1'b0;
    check("n2_b_resv",  32'(result2_valid), 32'd1);
    check("n2_b_idx",   32'(class2_idx),    32'd0);
    check("n2_b_score", 32'(class2_score),  32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_argmax.md
# neuron_argmax

Output stage of the neuron datapath, directly downstream of `mac_acc`. Takes one signed accumulated dot product per output neuron, applies arithmetic scaling, ReLU and 8-bit saturation, and streams each activation. It tracks the running maximum across one frame of `NUM_CLASSES` neurons and presents the winning class index and score through a valid/ready handshake.

## Interface
- `ACC_W`, 22: width of the signed accumulator input; matches `mac_acc` `dout`.
- `NUM_CLASSES`, 10: neurons per frame, range 2..16.
- `SHIFT`, 6: arithmetic right shift applied before ReLU, range 0..ACC_W-1.
- `OUT_W`, 8: activation/score width, unsigned.
- `IDX_W`, 4: class index width, at least clog2(NUM_CLASSES).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `acc_in`  in  ACC_W  signed accumulated sum for the current neuron.
- `acc_valid`  in  1  `acc_in` is valid this cycle.
- `acc_ready`  out  1  block accepts a sample this cycle.
- `act_out`  out  OUT_W  scaled, ReLU'd, saturated activation.
- `act_valid`  out  1  one-cycle pulse qualifying `act_out`.
- `class_idx`  out  IDX_W  index (0-based, arrival order) of the frame maximum.
- `class_score`  out  OUT_W  activation value of that maximum.
- `result_valid`  out  1  frame result held stable.
- `result_ready`  in  1  consumer takes the result.

## Operation
- Sample accepted when `acc_valid && acc_ready`.
- Activation: s = acc_in >>> SHIFT (sign-extending). If s < 0, act = 0. If s > 2^OUT_W-1, act = 2^OUT_W-1. Otherwise act = s[OUT_W-1:0].
- States:
  - ACC: `acc_ready`=1. Each accepted sample increments `cnt` (0..NUM_CLASSES-1). Comparison is against the running max `best_score` and `best_idx`. The sample at `cnt`=0 loads unconditionally. Later samples replace the max only if act > `best_score` (strict), so on a tie the lowest index wins. An accepted sample at `cnt`=NUM_CLASSES-1 moves the FSM to HOLD and resets `cnt` to 0.
  - HOLD: `acc_ready`=0. `result_valid`=1. `class_idx` and `class_score` are stable. If `result_ready`=1, the FSM returns to ACC next cycle.
- `acc_valid` while `acc_ready`=0 is ignored; the upstream must hold or drop the sample. Nothing is buffered.
- All-zero frame (every sample ≤ 0): result is idx 0, score 0.
- Reset mid-frame discards the partial frame. A reset during HOLD drops the pending result.

## Timing
- Reset values: state=ACC, `cnt`=0, `acc_ready`=1, `act_out`=0, `act_valid`=0, `class_idx`=0, `class_score`=0, `result_valid`=0.
- `acc_ready` and `result_valid` are decoded from registered state only. There is no combinational path from inputs to outputs.
- Activation latency is 1. A sample accepted at edge k gives `act_out`/`act_valid` valid after edge k (in cycle k+1), with `act_valid` high for exactly one cycle.
- Result latency is 1. When the last sample is accepted at edge k, `result_valid`=1 and `acc_ready`=0 from cycle k+1. The `act_valid` pulse for the last sample coincides with the first cycle of `result_valid`.
- Handshake completes at the edge where `result_valid && result_ready`. `acc_ready`=1 in the next cycle, so the minimum frame period is NUM_CLASSES+1 cycles.
- Back-to-back samples (`acc_valid` held high) are accepted every cycle in ACC.

## Structure
- Package `neuron_pkg`:
  - `ACC_W`=22 (shared with `mac_acc`) and the default `OUT_W`.
  - FSM enum `argmax_state_t` {ACC, HOLD}.
- Sub-module `relu_sat`: combinational shift/ReLU/saturate, parameterised by ACC_W, SHIFT and OUT_W. It is reusable by hidden layers.
- Top module contains the FSM, `cnt`, max registers and output registers.

## Test plan
- Scaling/clamp, with SHIFT=6: acc_in 0x000640 → act 25; 0x3FFFC0 (−64) → 0; 0x1FFFFF → 255; 0x00003F → 0. Each must appear with a single-cycle `act_valid`, one cycle after acceptance.
- Frame of 10 back-to-back samples with acts {3,9,40,7,40,1,0,12,39,2} → `result_valid` one cycle after sample 9, idx 2 (tie resolves to the lower index), score 40. `acc_ready`=0 while held.
- Backpressure: hold `result_ready`=0 for 5 cycles while driving `acc_valid`=1 → no sample accepted, result stable. Then `result_ready`=1 → `acc_ready`=1 the next cycle, and the next frame starts at `cnt`=0.
- All-negative frame → idx 0, score 0.
- Reset mid-frame: assert `rst_n`=0 after 4 samples, asynchronously between edges → all outputs go to reset values immediately. A following full frame with the max at index 7 (value 200) → idx 7, score 200.
- NUM_CLASSES=2 instance: samples 5, 6 → idx 1, score 6. Immediately after the handshake, a second frame 6, 5 → idx 0, score 6.
